spi_master: RTL and testbench
=============================

# spi_master

SPI mode-0 initiator: serialises one DATA_W-bit word onto mosi, MSB first, while capturing the word returned on miso, under a start/busy/done handshake from on-chip logic. It is the controller end for the team's SPI slave block. sclk idles low and mosi changes only while sclk is low, so the slave samples on the rising edge and shifts on the falling edge. The slave loads its transmit word on cs_n falling and latches its received word on cs_n rising. The block runs entirely in the clk domain; sclk is a registered output, not a clock.

## Interface
- CLK_DIV, 2: sclk half-period in clk cycles; legal range 1..255.
- DATA_W, 8: bits per transfer; legal range 2..32.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a transfer; sampled only when busy=0.
- tx_data  in  DATA_W  word to send; captured in the cycle start is accepted.
- busy  out  1  high from the cycle after acceptance until the done cycle; low during the done cycle.
- done  out  1  one-cycle pulse at transfer end.
- rx_data  out  DATA_W  last received word; updated in the done cycle, then held.
- sclk  out  1  serial clock, idle low.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in; ignored while cs_n=1.

## Operation
- Reset values: sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0.
- FSM states:
  - IDLE: start=1 latches tx_data into the shift register, goes to SETUP and loads the divider.
  - SETUP: cs_n=0, mosi=tx[DATA_W-1], sclk=0; lasts CLK_DIV cycles, then goes to HIGH.
  - HIGH: sclk=1; lasts CLK_DIV cycles, then goes to LOW.
  - LOW: sclk=0; lasts CLK_DIV cycles, then goes to HIGH if bits remain, else to IDLE with done=1.
- miso sampling: on the clk edge that raises sclk, miso is shifted into the receive register LSB.
- mosi shifting: on the clk edge that lowers sclk, the transmit register shifts left with 0 fill, and mosi takes the new MSB.
- Bit counter: width $clog2(DATA_W), loaded with DATA_W-1, decremented on each rising-sclk edge; LOW after the edge where the counter reads 0 is the final phase.
- Divider counter: width $clog2(CLK_DIV+1), reloaded on each state entry.
- start while busy=1 is ignored; tx_data changes after acceptance have no effect.
- Back-to-back: start=1 during the done cycle is accepted.
  - cs_n is high for exactly that one cycle, which gives the slave a fresh falling edge.
- Reset mid-transfer: the next cycle shows all reset values; no done pulse; the partial word is discarded.

## Timing
- start sampled at edge E0: cs_n=0 and mosi valid from E0+1.
- First sclk rise at E0+1+CLK_DIV.
- cs_n stays low for exactly (2·DATA_W+1)·CLK_DIV cycles.
- done=1 and cs_n=1 in the same cycle, (2·DATA_W+1)·CLK_DIV+1 cycles after E0.
- rx_data is valid in that same cycle.
- mosi setup before each sclk rise is CLK_DIV cycles; hold after each rise is CLK_DIV cycles.
- Exactly DATA_W sclk pulses per transfer; sclk is low when cs_n changes in either direction.
- busy=1 for (2·DATA_W+1)·CLK_DIV cycles.

## Structure
- Package spi_pkg:
  - state enum (IDLE, SETUP, HIGH, LOW);
  - DEFAULT_DATA_W=8;
  - mode-0 polarity constants CPOL=0 and CPHA=0, used by the master and by bench models.
- Sub-module spi_half_period_timer:
  - loadable down-counter of width $clog2(CLK_DIV+1);
  - input: load;
  - output: expire, asserted in the last cycle of each phase.
- Top level holds the FSM, bit counter, and the two shift registers.

## Test plan
- CLK_DIV=2, tx_data=0xA5, mode-0 slave model returns 0x3C:
  - mosi reads 1,0,1,0,0,1,0,1 at the 8 sclk rises;
  - rx_data=0x3C, done 35 cycles after start, cs_n low 34 cycles.
- CLK_DIV=1, tx_data=0xFF, miso held 0: 8 sclk pulses of 1 high / 1 low; rx_data=0x00; done 18 cycles after start.
- Back-to-back 0x12 then 0x34 (start held high):
  - cs_n high for exactly 1 cycle between transfers;
  - slave model receives 0x12 then 0x34.
- start pulsed every cycle during a transfer: no extra transfer, busy stays high, exactly one done.
- rst_n low at the 4th sclk rise: next cycle shows sclk=0, cs_n=1, mosi=0, busy=0, rx_data=0, and no done.
- CLK_DIV=3, DATA_W=16, tx=0xBEEF, miso returns 0x1234: rx_data=0x1234; cs_n low 99 cycles; 16 sclk pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 initiator and its bench models.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter that times one sclk half-period; expire marks the
// last clk cycle of the current phase.
module spi_half_period_timer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_expire
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one DATA_W-bit full-duplex word per start, MSB first,
// with all serial outputs registered in the clk domain.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_sclk,
  output logic              o_cs_n,
  output logic              o_mosi,
  input  logic              i_miso
);

  localparam int BW = $clog2(DATA_W);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_expire;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;
  logic              w_sample;
  logic              w_shift;
  logic              w_finish;
  logic              w_load;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_last;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_sclk;
  logic              r_cs_n;
  logic              r_busy;
  logic              r_done;

  spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start)  w_state_nxt = SETUP;
      SETUP:   if (w_expire) w_state_nxt = HIGH;
      HIGH:    if (w_expire) w_state_nxt = LOW;
      LOW:     if (w_expire) w_state_nxt = r_last ? IDLE : HIGH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == IDLE) && i_start;
    w_rise   = (r_state != HIGH) && (w_state_nxt == HIGH);
    w_fall   = (r_state == HIGH) && w_expire;
    w_finish = (r_state == LOW) && w_expire && r_last;
    // Every non-idle phase ends on expire, so each state entry reloads the timer.
    w_load   = w_accept || ((r_state != IDLE) && w_expire);
    w_sample = (CPHA == 1'b0) ? w_rise : w_fall;
    w_shift  = (CPHA == 1'b0) ? w_fall : w_rise;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sclk    <= CPOL;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_cnt <= '0;
      r_last    <= 1'b0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
    end else begin
      r_sclk <= (w_state_nxt == HIGH) ? ~CPOL : CPOL;
      r_cs_n <= (w_state_nxt == IDLE);
      r_busy <= (w_state_nxt != IDLE);
      r_done <= w_finish;
      if (w_accept) begin
        r_tx_sh   <= i_tx_data;
        r_bit_cnt <= BW'(DATA_W - 1);
        r_last    <= 1'b0;
      end
      if (w_rise) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
        if (r_bit_cnt == '0) r_last <= 1'b1;
      end
      if (w_sample) r_rx_sh <= {r_rx_sh[DATA_W-2:0], i_miso};
      if (w_shift)  r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
      if (w_finish) r_rx_data <= r_rx_sh;
    end
  end

  assign o_sclk    = r_sclk;
  assign o_cs_n    = r_cs_n;
  assign o_mosi    = r_tx_sh[DATA_W-1];
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (div2/8b, div1/8b, div3/16b) driven
// against a mode-0 slave model that runs on the falling clk edge.
module tb_spi_master;
  import spi_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start [3];
  logic        sclk  [3];
  logic        cs_n  [3];
  logic        mosi  [3];
  logic        busy  [3];
  logic        done  [3];
  logic        miso  [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] tx    [3];
  logic [31:0] rx    [3];
  logic [7:0]  rx_a;
  logic [7:0]  rx_b;
  logic [15:0] rx_c;

  assign rx[0] = {24'h0, rx_a};
  assign rx[1] = {24'h0, rx_b};
  assign rx[2] = {16'h0, rx_c};

  spi_master #(.CLK_DIV(2), .DATA_W(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_tx_data(tx[0][7:0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_rx_data(rx_a), .o_sclk(sclk[0]),
    .o_cs_n(cs_n[0]), .o_mosi(mosi[0]), .i_miso(miso[0]));

  spi_master #(.CLK_DIV(1), .DATA_W(8)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_tx_data(tx[1][7:0]),
    .o_busy(busy[1]), .o_done(done[1]), .o_rx_data(rx_b), .o_sclk(sclk[1]),
    .o_cs_n(cs_n[1]), .o_mosi(mosi[1]), .i_miso(miso[1]));

  spi_master #(.CLK_DIV(3), .DATA_W(16)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_tx_data(tx[2][15:0]),
    .o_busy(busy[2]), .o_done(done[2]), .o_rx_data(rx_c), .o_sclk(sclk[2]),
    .o_cs_n(cs_n[2]), .o_mosi(mosi[2]), .i_miso(miso[2]));

  // Slave model state, one slot per instance.
  logic [31:0] s_tx   [3];
  logic [31:0] s_rx   [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] s_got  [3] = '{32'h0, 32'h0, 32'h0};
  logic        prev_cs[3] = '{1'b1, 1'b1, 1'b1};
  logic        prev_sk[3] = '{1'b0, 1'b0, 1'b0};
  int s_pos    [3] = '{0, 0, 0};
  int hi_run   [3] = '{0, 0, 0};
  int cs_run   [3] = '{0, 0, 0};
  int last_hi  [3] = '{0, 0, 0};
  int last_cs  [3] = '{0, 0, 0};
  int rises    [3] = '{0, 0, 0};
  int hi_cyc   [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int edge_viol[3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (prev_cs[i] && !cs_n[i]) begin
        last_hi[i] = hi_run[i];
        hi_run[i]  = 0;
        cs_run[i]  = 0;
        s_pos[i]   = (i == 2) ? 15 : 7;
        s_rx[i]    = '0;
        miso[i]    = s_tx[i][s_pos[i]];
        if (sclk[i] != CPOL) edge_viol[i]++;
      end
      if (!prev_cs[i] && cs_n[i]) begin
        last_cs[i] = cs_run[i];
        s_got[i]   = s_rx[i];
        if (sclk[i] != CPOL) edge_viol[i]++;
      end
      if (cs_n[i]) hi_run[i]++;
      else         cs_run[i]++;
      if (sclk[i]) hi_cyc[i]++;
      if (sclk[i] && !prev_sk[i]) begin
        rises[i]++;
        if (CPHA == 1'b0) s_rx[i] = {s_rx[i][30:0], mosi[i]};
      end
      if (!sclk[i] && prev_sk[i]) begin
        if (s_pos[i] > 0) s_pos[i]--;
        miso[i] = s_tx[i][s_pos[i]];
      end
      if (done[i]) done_cnt[i]++;
      prev_cs[i] = cs_n[i];
      prev_sk[i] = sclk[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int          inst;
    logic [31:0] tx;
    logic [31:0] sw;
    int          lat;
    int          cs_low;
    int          n_rise;
    int          n_hi;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int k, input vec_t v);
    int i, n, nb, d0, r0, h0;
    i  = v.inst;
    s_tx[i] = v.sw;
    tick();
    d0 = done_cnt[i];
    r0 = rises[i];
    h0 = hi_cyc[i];
    tx[i]    = v.tx;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    n  = 0;
    nb = 0;
    do begin
      tick();
      n++;
      if (busy[i]) nb++;
    end while (!done[i] && n < 300);
    chk($sformatf("v%0d done_latency", k), n, v.lat);
    chk($sformatf("v%0d rx_data", k), rx[i], v.sw);
    chk($sformatf("v%0d slave_rx", k), s_got[i], v.tx);
    chk($sformatf("v%0d cs_low", k), last_cs[i], v.cs_low);
    chk($sformatf("v%0d busy_cycles", k), nb, v.cs_low);
    chk($sformatf("v%0d sclk_pulses", k), rises[i] - r0, v.n_rise);
    chk($sformatf("v%0d sclk_high_cycles", k), hi_cyc[i] - h0, v.n_hi);
    chk($sformatf("v%0d done_pulses", k), done_cnt[i] - d0, 1);
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done[i] && n < 300);
  endtask

  initial begin
    int n, d0, r0, nb;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      tx[i]    = '0;
      s_tx[i]  = '0;
    end
    vecs[0] = '{0, 32'h00A5, 32'h003C, 35, 34, 8, 16};
    vecs[1] = '{1, 32'h00FF, 32'h0000, 18, 17, 8, 8};
    vecs[2] = '{2, 32'hBEEF, 32'h1234, 100, 99, 16, 48};
    vecs[3] = '{0, 32'h005A, 32'h00C3, 35, 34, 8, 16};
    vecs[4] = '{1, 32'h0081, 32'h007E, 18, 17, 8, 8};
    vecs[5] = '{2, 32'h0001, 32'h8000, 100, 99, 16, 48};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d sclk", i), {31'h0, sclk[i]}, 32'h0);
      chk($sformatf("rst%0d cs_n", i), {31'h0, cs_n[i]}, 32'h1);
      chk($sformatf("rst%0d mosi", i), {31'h0, mosi[i]}, 32'h0);
      chk($sformatf("rst%0d busy", i), {31'h0, busy[i]}, 32'h0);
      chk($sformatf("rst%0d done", i), {31'h0, done[i]}, 32'h0);
      chk($sformatf("rst%0d rx_data", i), rx[i], 32'h0);
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Back-to-back on the div-2 instance with start held high throughout.
    s_tx[0] = 32'h77;
    tick();
    d0 = done_cnt[0];
    tx[0]    = 32'h12;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    tx[0] = 32'h34;
    wait_done(0, n);
    chk("b2b first_latency", n, 35);
    chk("b2b first_slave_rx", s_got[0], 32'h12);
    chk("b2b first_rx_data", rx[0], 32'h77);
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, n);
    chk("b2b second_latency", n, 35);
    chk("b2b second_slave_rx", s_got[0], 32'h34);
    chk("b2b cs_high_gap", last_hi[0], 1);
    chk("b2b done_pulses", done_cnt[0] - d0, 2);

    // start asserted every cycle of a transfer on the div-1 instance.
    s_tx[1] = 32'h96;
    tick();
    d0 = done_cnt[1];
    tx[1]    = 32'h5A;
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    n  = 0;
    nb = 0;
    do begin
      tick();
      tx[1] = 32'($urandom_range(0, 255));
      n++;
      if (busy[1]) nb++;
    end while (!done[1] && n < 300);
    start[1] = 1'b0;
    chk("storm latency", n, 18);
    chk("storm busy_cycles", nb, 17);
    chk("storm slave_rx", s_got[1], 32'h5A);
    chk("storm rx_data", rx[1], 32'h96);
    repeat (30) tick();
    chk("storm done_pulses", done_cnt[1] - d0, 1);
    chk("storm cs_n_idle", {31'h0, cs_n[1]}, 32'h1);

    // Reset asserted as the 4th sclk pulse rises on the div-2 instance.
    s_tx[0] = 32'hFF;
    tick();
    d0 = done_cnt[0];
    r0 = rises[0];
    tx[0]    = 32'hF0;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while ((rises[0] - r0) < 4 && n < 300);
    chk("mid_rst reached_4th_rise", rises[0] - r0, 4);
    chk("mid_rst mosi_before", {31'h0, mosi[0]}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst sclk", {31'h0, sclk[0]}, 32'h0);
    chk("mid_rst cs_n", {31'h0, cs_n[0]}, 32'h1);
    chk("mid_rst mosi", {31'h0, mosi[0]}, 32'h0);
    chk("mid_rst busy", {31'h0, busy[0]}, 32'h0);
    chk("mid_rst done", {31'h0, done[0]}, 32'h0);
    chk("mid_rst rx_data", rx[0], 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("mid_rst no_done", done_cnt[0] - d0, 0);
    chk("mid_rst cs_n_idle", {31'h0, cs_n[0]}, 32'h1);

    chk("sclk_low_at_cs_edges", edge_viol[0] + edge_viol[1] + edge_viol[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
